// File: rtl/ring_router_pkg.sv
// Shared constants for the two-VC bidirectional ring router: header bit positions,
// port indices and the fixed requester wiring of the per-output arbiters.
package ring_router_pkg;

    localparam int unsigned CW     = 0;
    localparam int unsigned CCW    = 1;
    localparam int unsigned PE     = 2;
    localparam int unsigned NPORTS = 3;
    localparam int unsigned NVC    = 2;

    function automatic int unsigned VC_BIT(input int unsigned psize);
        return psize - 1;
    endfunction

    function automatic int unsigned DIR_BIT(input int unsigned psize);
        return psize - 2;
    endfunction

    function automatic int unsigned HOP_MSB(input int unsigned psize);
        return psize - 9;
    endfunction

    function automatic int unsigned HOP_LSB(input int unsigned psize, input int unsigned hop_width);
        return psize - 8 - hop_width;
    endfunction

    // Input port feeding requester k (0 = ring side, 1 = other) of an output's arbiter.
    function automatic int unsigned ARB_SRC(input int unsigned out_port, input logic k);
        case (out_port)
            CW:      return k ? PE : CW;
            CCW:     return k ? PE : CCW;
            default: return k ? CCW : CW;
        endcase
    endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Count-based circular buffer holding one virtual channel of a router port.
// DEPTH may be any integer >= 1; pointers wrap explicitly at DEPTH-1.
module router_vc_fifo
    import ring_router_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CNTW-1:0]  r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full    = (r_cnt == CNTW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_dout    = r_mem[r_rd];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= next_ptr(r_wr);
            end
            if (w_pop_ok) begin
                r_rd <= next_ptr(r_rd);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_router_vc.sv
// Bidirectional ring router node with two time-multiplexed VCs per port: links use
// VC[polarity] while the switch moves VC[~polarity], so no buffer is pushed and popped together.
module ring_router_vc
    import ring_router_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = 64,
    parameter int unsigned BUF_DEPTH   = 1,
    parameter int unsigned HOP_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   polarity,
    input  logic                   cwsi,
    output logic                   cwri,
    input  logic [PACKET_SIZE-1:0] cwdi,
    input  logic                   ccwsi,
    output logic                   ccwri,
    input  logic [PACKET_SIZE-1:0] ccwdi,
    input  logic                   pesi,
    output logic                   peri,
    input  logic [PACKET_SIZE-1:0] pedi,
    output logic                   cwso,
    input  logic                   cwro,
    output logic [PACKET_SIZE-1:0] cwdo,
    output logic                   ccwso,
    input  logic                   ccwro,
    output logic [PACKET_SIZE-1:0] ccwdo,
    output logic                   peso,
    input  logic                   pero,
    output logic [PACKET_SIZE-1:0] pedo
);

    localparam int unsigned P  = PACKET_SIZE;
    localparam int unsigned DB = DIR_BIT(P);
    localparam int unsigned HM = HOP_MSB(P);
    localparam int unsigned HL = HOP_LSB(P, HOP_WIDTH);

    logic                                r_pol;
    logic [NPORTS-1:0]                   r_ptr;
    logic                                w_sw;
    logic [NPORTS-1:0]                   w_si, w_ro, w_ri, w_so;
    logic [NPORTS-1:0][P-1:0]            w_in_din, w_out_din, w_do, w_head, w_mod;
    logic [NPORTS-1:0][NVC-1:0]          w_in_push, w_in_pop, w_in_full, w_in_empty;
    logic [NPORTS-1:0][NVC-1:0]          w_out_push, w_out_pop, w_out_full, w_out_empty;
    logic [NPORTS-1:0][NVC-1:0][P-1:0]   w_in_dout, w_out_dout;
    logic [NPORTS-1:0][NPORTS-1:0]       w_route, w_rq, w_gnt;
    logic [NPORTS-1:0]                   w_r0, w_r1, w_g0, w_g1;

    assign w_sw     = ~r_pol;
    assign w_si     = {pesi, ccwsi, cwsi};
    assign w_ro     = {pero, ccwro, cwro};
    assign w_in_din = {pedi, ccwdi, cwdi};

    assign polarity = r_pol;
    assign cwri     = w_ri[CW];
    assign ccwri    = w_ri[CCW];
    assign peri     = w_ri[PE];
    assign cwso     = w_so[CW];
    assign ccwso    = w_so[CCW];
    assign peso     = w_so[PE];
    assign cwdo     = w_do[CW];
    assign ccwdo    = w_do[CCW];
    assign pedo     = w_do[PE];

    for (genvar p = 0; p < NPORTS; p++) begin : g_link
        assign w_ri[p]   = !w_in_full[p][r_pol];
        assign w_so[p]   = !w_out_empty[p][r_pol];
        assign w_do[p]   = w_so[p] ? w_out_dout[p][r_pol] : '0;
        assign w_head[p] = w_in_dout[p][w_sw];
        for (genvar v = 0; v < NVC; v++) begin : g_vc
            assign w_in_push[p][v] = w_si[p] && w_ri[p] && (r_pol == 1'(v));
            assign w_out_pop[p][v] = w_so[p] && w_ro[p] && (r_pol == 1'(v));
            assign w_in_pop[p][v]  = (w_sw == 1'(v)) && (|w_gnt[p]);

            router_vc_fifo #(.WIDTH(P), .DEPTH(BUF_DEPTH)) u_in (
                .clk     (clk),
                .reset   (reset),
                .i_push  (w_in_push[p][v]),
                .i_din   (w_in_din[p]),
                .i_pop   (w_in_pop[p][v]),
                .o_dout  (w_in_dout[p][v]),
                .o_full  (w_in_full[p][v]),
                .o_empty (w_in_empty[p][v])
            );

            router_vc_fifo #(.WIDTH(P), .DEPTH(BUF_DEPTH)) u_out (
                .clk     (clk),
                .reset   (reset),
                .i_push  (w_out_push[p][v]),
                .i_din   (w_out_din[p]),
                .i_pop   (w_out_pop[p][v]),
                .o_dout  (w_out_dout[p][v]),
                .o_full  (w_out_full[p][v]),
                .o_empty (w_out_empty[p][v])
            );
        end
    end

    // Ring inputs continue along the ring while hop[0] is set, consuming one hop per router.
    always_comb begin
        w_mod   = w_head;
        w_route = '0;
        if (w_head[CW][HL]) begin
            w_route[CW][CW]    = 1'b1;
            w_mod[CW][HM:HL]   = w_head[CW][HM:HL] >> 1;
        end else begin
            w_route[CW][PE]    = 1'b1;
        end
        if (w_head[CCW][HL]) begin
            w_route[CCW][CCW]  = 1'b1;
            w_mod[CCW][HM:HL]  = w_head[CCW][HM:HL] >> 1;
        end else begin
            w_route[CCW][PE]   = 1'b1;
        end
        if (w_head[PE][DB]) begin
            w_route[PE][CW]    = 1'b1;
        end else begin
            w_route[PE][CCW]   = 1'b1;
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_req
        for (genvar o = 0; o < NPORTS; o++) begin : g_out
            assign w_rq[i][o] = w_route[i][o] && !w_in_empty[i][w_sw] && !w_out_full[o][w_sw];
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        localparam int unsigned S0 = ARB_SRC(o, 1'b0);
        localparam int unsigned S1 = ARB_SRC(o, 1'b1);

        assign w_r0[o]      = w_rq[S0][o];
        assign w_r1[o]      = w_rq[S1][o];
        assign w_g0[o]      = w_r0[o] && (!w_r1[o] || !r_ptr[o]);
        assign w_g1[o]      = w_r1[o] && (!w_r0[o] || r_ptr[o]);
        assign w_out_din[o] = w_g0[o] ? w_mod[S0] : w_mod[S1];

        for (genvar v = 0; v < NVC; v++) begin : g_push
            assign w_out_push[o][v] = (w_g0[o] || w_g1[o]) && (w_sw == 1'(v));
        end

        for (genvar i = 0; i < NPORTS; i++) begin : g_gnt
            if (i == int'(S0)) begin : g_s0
                assign w_gnt[i][o] = w_g0[o];
            end else if (i == int'(S1)) begin : g_s1
                assign w_gnt[i][o] = w_g1[o];
            end else begin : g_none
                assign w_gnt[i][o] = 1'b0;
            end
        end
    end

    // Pointer moves to requester 1 after granting requester 0 and back after granting 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pol <= 1'b0;
            r_ptr <= '0;
        end else begin
            r_pol <= ~r_pol;
            r_ptr <= (r_ptr & ~(w_g0 | w_g1)) | w_g0;
        end
    end

endmodule

// File: tb/tb_ring_router_vc.sv
// Directed bench for ring_router_vc (BUF_DEPTH=2): a per-cycle vector table for routing,
// then hand-written sequences for reset flush, arbitration contention and backpressure.
module tb_ring_router_vc;

    localparam int unsigned PS = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          cwsi, ccwsi, pesi;
    logic          cwri, ccwri, peri;
    logic [PS-1:0] cwdi, ccwdi, pedi;
    logic          cwso, ccwso, peso;
    logic          cwro, ccwro, pero;
    logic [PS-1:0] cwdo, ccwdo, pedo;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_pol;

    always #5 clk = ~clk;

    ring_router_vc #(.PACKET_SIZE(PS), .BUF_DEPTH(2), .HOP_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
        .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
        .pesi(pesi), .peri(peri), .pedi(pedi),
        .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
        .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
        .peso(peso), .pero(pero), .pedo(pedo)
    );

    typedef struct {
        logic          cwsi, ccwsi, pesi;
        logic [PS-1:0] cwdi, ccwdi, pedi;
        logic          pol;
        logic [2:0]    so;          // {pe, ccw, cw}
        logic [PS-1:0] cwdo, ccwdo, pedo;
    } vec_t;

    vec_t tbl [15];

    // hop field is bits [55:48]; bit 62 = dir (1 = cw), bit 63 = vc (ignored)
    localparam logic [PS-1:0] PA  = 64'h4000_0000_0000_0001;
    localparam logic [PS-1:0] PB  = 64'h0003_0000_0000_00B0;
    localparam logic [PS-1:0] PBX = 64'h0001_0000_0000_00B0;
    localparam logic [PS-1:0] PC  = 64'h8000_0000_0000_00C0;
    localparam logic [PS-1:0] PD  = 64'h0000_0000_0000_00D0;
    localparam logic [PS-1:0] PE_ = 64'h0005_0000_0000_00E0;
    localparam logic [PS-1:0] PEX = 64'h0002_0000_0000_00E0;
    localparam logic [PS-1:0] PF  = 64'h0000_0000_0000_00F0;
    localparam logic [PS-1:0] G1  = 64'h0000_0000_0000_0A01;
    localparam logic [PS-1:0] G2  = 64'h0000_0000_0000_0A02;
    localparam logic [PS-1:0] G3  = 64'h4000_0000_0000_0A03;
    localparam logic [PS-1:0] CW1 = 64'h0001_0000_0000_0011;
    localparam logic [PS-1:0] CW2 = 64'h0001_0000_0000_0012;
    localparam logic [PS-1:0] PE1 = 64'h4000_0000_0000_0021;
    localparam logic [PS-1:0] PE2 = 64'h4000_0000_0000_0022;
    localparam logic [PS-1:0] JNK = 64'h0001_0000_0000_0BFF;

    function automatic vec_t mkv(logic cs, logic [PS-1:0] cd, logic ccs, logic [PS-1:0] ccd,
                                 logic ps, logic [PS-1:0] pd, logic pol, logic [2:0] so,
                                 logic [PS-1:0] ecw, logic [PS-1:0] eccw, logic [PS-1:0] epe);
        vec_t r;
        r.cwsi = cs;  r.cwdi = cd;  r.ccwsi = ccs; r.ccwdi = ccd;
        r.pesi = ps;  r.pedi = pd;  r.pol = pol;   r.so = so;
        r.cwdo = ecw; r.ccwdo = eccw; r.pedo = epe;
        return r;
    endfunction

    task automatic chk(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic epol, input logic [2:0] eri,
                           input logic [2:0] eso, input logic [PS-1:0] ecw,
                           input logic [PS-1:0] eccw, input logic [PS-1:0] epe);
        chk({tag, ".pol"},   64'(polarity), 64'(epol));
        chk({tag, ".ri"},    64'({peri, ccwri, cwri}), 64'(eri));
        chk({tag, ".so"},    64'({peso, ccwso, cwso}), 64'(eso));
        chk({tag, ".cwdo"},  cwdo,  ecw);
        chk({tag, ".ccwdo"}, ccwdo, eccw);
        chk({tag, ".pedo"},  pedo,  epe);
    endtask

    task automatic step();
        @(negedge clk);
        exp_pol = ~exp_pol;
    endtask

    task automatic idle_in();
        cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
        cwdi = '0;   ccwdi = '0;   pedi = '0;
    endtask

    initial begin
        logic [PS-1:0] cseq [4];
        logic [PS-1:0] wp   [4];
        logic [PS-1:0] wpx  [4];

        tbl[0]  = mkv(0, '0, 0, '0, 0, '0, 0, 3'b000, '0, '0, '0);
        tbl[1]  = mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, '0, '0, '0);
        tbl[2]  = mkv(0, '0, 0, '0, 0, '0, 0, 3'b000, '0, '0, '0);
        tbl[3]  = mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, '0, '0, '0);
        tbl[4]  = mkv(0, '0, 0, '0, 1, PA, 0, 3'b000, '0, '0, '0);
        tbl[5]  = mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, '0, '0, '0);
        tbl[6]  = mkv(0, '0, 0, '0, 0, '0, 0, 3'b001, PA, '0, '0);
        tbl[7]  = mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, '0, '0, '0);
        tbl[8]  = mkv(1, PB, 1, PC, 0, '0, 0, 3'b000, '0, '0, '0);
        tbl[9]  = mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, '0, '0, '0);
        tbl[10] = mkv(1, PD, 1, PE_, 0, '0, 0, 3'b101, PBX, '0, PC);
        tbl[11] = mkv(0, '0, 0, '0, 1, PF, 1, 3'b000, '0, '0, '0);
        tbl[12] = mkv(0, '0, 0, '0, 0, '0, 0, 3'b110, '0, PEX, PD);
        tbl[13] = mkv(0, '0, 0, '0, 0, '0, 1, 3'b010, '0, PF, '0);
        tbl[14] = mkv(0, '0, 0, '0, 0, '0, 0, 3'b000, '0, '0, '0);

        cseq[0] = 64'h0000_0000_0000_0011;
        cseq[1] = PE1;
        cseq[2] = 64'h0000_0000_0000_0012;
        cseq[3] = PE2;
        for (int n = 0; n < 4; n++) begin
            wp[n]  = 64'h0001_0000_0000_0B00 + 64'(n);
            wpx[n] = 64'h0000_0000_0000_0B00 + 64'(n);
        end

        reset = 1'b1;
        idle_in();
        cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_pol = 1'b0;

        // routing vectors, one row per cycle
        for (int i = 0; i < 15; i++) begin
            chk_all($sformatf("row%0d", i), tbl[i].pol, 3'b111, tbl[i].so,
                    tbl[i].cwdo, tbl[i].ccwdo, tbl[i].pedo);
            cwsi = tbl[i].cwsi; cwdi = tbl[i].cwdi;
            ccwsi = tbl[i].ccwsi; ccwdi = tbl[i].ccwdi;
            pesi = tbl[i].pesi; pedi = tbl[i].pedi;
            step();
        end
        idle_in();

        // reset with packets buffered; pe-out pointer favours ccw after the earlier D grant
        if (exp_pol) step();
        cwro = 1'b0; pero = 1'b0;
        cwsi = 1'b1; cwdi = G1; ccwsi = 1'b1; ccwdi = G2; pesi = 1'b1; pedi = G3;
        step();
        idle_in();
        step();
        chk("rst.pre.cwso", 64'(cwso), 64'd1);
        chk("rst.pre.cwdo", cwdo, G3);
        chk("rst.pre.peso", 64'(peso), 64'd1);
        chk("rst.pre.pedo", pedo, G2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_pol = 1'b0;
        chk_all("rst.after", 1'b0, 3'b111, 3'b000, '0, '0, '0);
        cwro = 1'b1; pero = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_all($sformatf("rst.idle%0d", i), exp_pol, 3'b111, 3'b000, '0, '0, '0);
            step();
        end

        // contention on cw out VC0: cw in and pe in alternate, starting with the ring input
        chk_all("cont.start", exp_pol, 3'b111, 3'b000, '0, '0, '0);
        cwsi = 1'b1; cwdi = CW1; pesi = 1'b1; pedi = PE1;
        step();
        idle_in();
        chk("cont.b.cwso", 64'(cwso), 64'd0);
        step();
        chk("cont.0.cwso", 64'(cwso), 64'd1);
        chk("cont.0.cwdo", cwdo, cseq[0]);
        cwsi = 1'b1; cwdi = CW2; pesi = 1'b1; pedi = PE2;
        step();
        idle_in();
        chk("cont.d.cwso", 64'(cwso), 64'd0);
        step();
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("cont.%0d.cwso", k), 64'(cwso), 64'd1);
            chk($sformatf("cont.%0d.cwdo", k), cwdo, cseq[k]);
            step();
            chk($sformatf("cont.%0d.gap", k), 64'(cwso), 64'd0);
            step();
        end
        chk("cont.end.cwso", 64'(cwso), 64'd0);

        // backpressure: cwro low, fill out_cw[0] and in_cw[0] (depth 2 each)
        cwro = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("bp.fill%0d.cwri", n), 64'(cwri), 64'd1);
            cwsi = 1'b1; cwdi = wp[n];
            step();
            cwsi = 1'b0;
            chk($sformatf("bp.fill%0d.odd.cwri", n), 64'(cwri), 64'd1);
            step();
        end
        for (int h = 0; h < 10; h++) begin
            if (exp_pol == 1'b0) begin
                chk($sformatf("bp.hold%0d.cwri", h), 64'(cwri), 64'd0);
                chk($sformatf("bp.hold%0d.cwso", h), 64'(cwso), 64'd1);
                chk($sformatf("bp.hold%0d.cwdo", h), cwdo, wpx[0]);
                cwsi = 1'b1; cwdi = JNK;
            end else begin
                cwsi = 1'b0;
                chk($sformatf("bp.hold%0d.odd.cwri", h), 64'(cwri), 64'd1);
                chk($sformatf("bp.hold%0d.odd.cwso", h), 64'(cwso), 64'd0);
            end
            step();
        end
        cwsi = 1'b0;
        cwro = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("bp.drain%0d.cwso", n), 64'(cwso), 64'd1);
            chk($sformatf("bp.drain%0d.cwdo", n), cwdo, wpx[n]);
            step();
            step();
        end
        chk_all("bp.empty", exp_pol, 3'b111, 3'b000, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
